// File: rtl/memory_stage_lsu.sv
// MEM pipeline stage: load/store unit driving a req/ack data-memory port,
// wait-cycle timeout with abort, and the MEM/WB pipeline register with fault code.
module memory_stage_lsu #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    input  logic [31:0] PCPlus4_M,
    input  logic [4:0]  RD_M,
    input  logic [2:0]  funct3_M,
    input  logic        rd_wren_M,
    input  logic        mem_wren_M,
    input  logic        insn_vld_M,
    input  logic [1:0]  wb_sel_M,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall_M,
    output logic [31:0] ALUResult_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] PCPlus4_W,
    output logic [4:0]  RD_W,
    output logic        rd_wren_W,
    output logic        insn_vld_W,
    output logic [1:0]  wb_sel_W,
    output logic [1:0]  fault_W
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] alu_q, alu_d, rdata_q, rdata_d, pc4_q, pc4_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_wren_q, rd_wren_d, insn_vld_q, insn_vld_d;
    logic [1:0]  wb_sel_q, wb_sel_d, fault_q, fault_d;

    logic        mem_op, width_ok, misaligned, access, abort, complete;
    logic [1:0]  fault_code;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        mem_op = insn_vld_M & (mem_wren_M | (wb_sel_M == 2'b01));
        case (funct3_M)
            3'b000, 3'b001, 3'b010: width_ok = 1'b1;
            3'b100, 3'b101:         width_ok = ~mem_wren_M;
            default:                width_ok = 1'b0;
        endcase
        misaligned = ((funct3_M[1:0] == 2'b01) & ALUResult_M[0])
                   | ((funct3_M[1:0] == 2'b10) & (|ALUResult_M[1:0]));
        fault_code = 2'b00;
        if (mem_op & ~width_ok)        fault_code = 2'b11;
        else if (mem_op & misaligned)  fault_code = 2'b01;
        access = mem_op & width_ok & ~misaligned;
    end

    always_comb begin
        o_dmem_be    = '0;
        o_dmem_wdata = '0;
        if (access & mem_wren_M) begin
            case (funct3_M[1:0])
                2'b00: begin
                    o_dmem_be    = 4'b0001 << ALUResult_M[1:0];
                    o_dmem_wdata = {4{WriteData_M[7:0]}};
                end
                2'b01: begin
                    o_dmem_be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
                    o_dmem_wdata = {2{WriteData_M[15:0]}};
                end
                default: begin
                    o_dmem_be    = 4'b1111;
                    o_dmem_wdata = WriteData_M;
                end
            endcase
        end
    end

    assign o_dmem_req  = access;
    assign o_dmem_we   = mem_wren_M;
    assign o_dmem_addr = {ALUResult_M[31:2], 2'b00};

    always_comb begin
        case (ALUResult_M[1:0])
            2'b00:   ld_byte = i_dmem_rdata[7:0];
            2'b01:   ld_byte = i_dmem_rdata[15:8];
            2'b10:   ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = ALUResult_M[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_M)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    // Access FSM: wait_cnt counts request cycles already spent in WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        abort      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access & ~i_dmem_ack) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            S_WAIT: begin
                if (~access | i_dmem_ack) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    abort      = 1'b1;
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
        complete  = access & i_dmem_ack;
        o_stall_M = access & ~i_dmem_ack & ~abort;
    end

    always_comb begin
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        pc4_d      = pc4_q;
        rd_d       = rd_q;
        wb_sel_d   = wb_sel_q;
        rd_wren_d  = 1'b0;
        insn_vld_d = 1'b0;
        fault_d    = 2'b00;
        if (~o_stall_M) begin
            alu_d      = ALUResult_M;
            pc4_d      = PCPlus4_M;
            rd_d       = RD_M;
            wb_sel_d   = wb_sel_M;
            insn_vld_d = insn_vld_M;
            rdata_d    = complete ? ld_data : '0;
            rd_wren_d  = rd_wren_M & (fault_code == 2'b00) & ~abort;
            fault_d    = abort ? 2'b10 : fault_code;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            rd_q       <= '0;
            rd_wren_q  <= 1'b0;
            insn_vld_q <= 1'b0;
            wb_sel_q   <= '0;
            fault_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            pc4_q      <= pc4_d;
            rd_q       <= rd_d;
            rd_wren_q  <= rd_wren_d;
            insn_vld_q <= insn_vld_d;
            wb_sel_q   <= wb_sel_d;
            fault_q    <= fault_d;
        end
    end

    assign ALUResult_W = alu_q;
    assign ReadData_W  = rdata_q;
    assign PCPlus4_W   = pc4_q;
    assign RD_W        = rd_q;
    assign rd_wren_W   = rd_wren_q;
    assign insn_vld_W  = insn_vld_q;
    assign wb_sel_W    = wb_sel_q;
    assign fault_W     = fault_q;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Randomized bench for memory_stage_lsu against an arithmetic reference model
// of the MEM stage, plus directed boundary scenarios.
module tb_memory_stage_lsu;

    localparam int MW = 4;
    localparam int NEVER = 99;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] ALUResult_M, WriteData_M, PCPlus4_M;
    logic [4:0]  RD_M;
    logic [2:0]  funct3_M;
    logic        rd_wren_M, mem_wren_M, insn_vld_M;
    logic [1:0]  wb_sel_M;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_stall_M;
    logic [31:0] ALUResult_W, ReadData_W, PCPlus4_W;
    logic [4:0]  RD_W;
    logic        rd_wren_W, insn_vld_W;
    logic [1:0]  wb_sel_W, fault_W;

    memory_stage_lsu #(.MAX_WAIT(MW)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M),
        .RD_M(RD_M), .funct3_M(funct3_M), .rd_wren_M(rd_wren_M), .mem_wren_M(mem_wren_M),
        .insn_vld_M(insn_vld_M), .wb_sel_M(wb_sel_M),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata), .o_stall_M(o_stall_M),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W), .PCPlus4_W(PCPlus4_W),
        .RD_W(RD_W), .rd_wren_W(rd_wren_W), .insn_vld_W(insn_vld_W),
        .wb_sel_W(wb_sel_W), .fault_W(fault_W)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int last_stalls, last_reqs;
    logic [3:0]  first_be;
    logic [31:0] first_wdata, first_addr;

    // expected MEM/WB contents that survive bubbles
    logic [31:0] m_alu = '0, m_rdata = '0, m_pc = '0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_wbsel = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [1:0] ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 2'b11;
        if ((a % ref_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int unsigned nb;
        logic [31:0] mask, v;
        nb = ref_size(f3);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> (8 * (a % 4))) & mask;
        if (!f3[2] && nb < 4 && (((v >> (8 * nb - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned nb;
        nb = ref_size(f3);
        return ((32'd1 << nb) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int unsigned nb;
        nb = ref_size(f3);
        if (nb == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // One EX/MEM instruction; delay = cycle index of the ack (NEVER = no ack).
    task automatic run_op(input bit vld, input bit st, input logic [1:0] wbs, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                          input int delay, input bit rdw);
        bit memop, acc, tmo, stall_e, done;
        logic [1:0] flt;
        logic [31:0] pc;
        logic [4:0] rd;
        int c;
        pc = $urandom;
        rd = 5'($urandom);
        ALUResult_M = a; WriteData_M = wd; PCPlus4_M = pc; RD_M = rd; funct3_M = f3;
        rd_wren_M = rdw; mem_wren_M = st; insn_vld_M = vld; wb_sel_M = wbs;
        memop = vld && (st || wbs == 2'b01);
        flt = memop ? ref_fault(st, f3, a) : 2'b00;
        acc = memop && flt == 2'b00;
        last_stalls = 0; last_reqs = 0;
        c = 0; done = 0;
        while (!done) begin
            i_dmem_ack   = (c == delay);
            i_dmem_rdata = (c == delay) ? rdv : $urandom;
            tmo = acc && c == MW - 1 && c != delay;
            stall_e = acc && c < delay && !tmo;
            @(negedge i_clk);
            check("req", 32'(o_dmem_req), 32'(acc));
            check("stall", 32'(o_stall_M), 32'(stall_e));
            if (o_stall_M) last_stalls++;
            if (o_dmem_req) last_reqs++;
            if (acc) begin
                if (c == 0) begin
                    first_be = o_dmem_be; first_wdata = o_dmem_wdata; first_addr = o_dmem_addr;
                end
                check("addr", o_dmem_addr, a & ~32'd3);
                check("we", 32'(o_dmem_we), 32'(st));
                check("be", 32'(o_dmem_be), st ? ref_be(f3, a) : 32'd0);
                check("wdata", o_dmem_wdata, st ? ref_wdata(f3, wd) : 32'd0);
            end
            @(posedge i_clk);
            #1;
            if (stall_e) begin
                check("bub_vld", 32'(insn_vld_W), 32'd0);
                check("bub_wren", 32'(rd_wren_W), 32'd0);
                check("bub_fault", 32'(fault_W), 32'd0);
                check("bub_alu", ALUResult_W, m_alu);
                check("bub_rdata", ReadData_W, m_rdata);
                c++;
                if (c > MW + 1) begin
                    check("cycle_budget", 32'(c), 32'(MW));
                    done = 1;
                end
            end else begin
                m_alu = a; m_pc = pc; m_rd = rd; m_wbsel = wbs;
                m_rdata = (acc && c == delay) ? ref_load(f3, a, rdv) : 32'd0;
                check("wb_alu", ALUResult_W, m_alu);
                check("wb_pc", PCPlus4_W, m_pc);
                check("wb_rd", 32'(RD_W), 32'(m_rd));
                check("wb_sel", 32'(wb_sel_W), 32'(m_wbsel));
                check("wb_rdata", ReadData_W, m_rdata);
                check("wb_vld", 32'(insn_vld_W), 32'(vld));
                check("wb_wren", 32'(rd_wren_W), 32'(rdw && flt == 2'b00 && !tmo));
                check("wb_fault", 32'(fault_W), tmo ? 32'd2 : 32'(flt));
                done = 1;
            end
        end
        i_dmem_ack = 1'b0;
    endtask

    task automatic idle_inputs();
        ALUResult_M = '0; WriteData_M = '0; PCPlus4_M = '0; RD_M = '0; funct3_M = '0;
        rd_wren_M = 0; mem_wren_M = 0; insn_vld_M = 0; wb_sel_M = '0;
        i_dmem_ack = 0; i_dmem_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(o_dmem_req), 32'd0);
        check({tag, "_stall"}, 32'(o_stall_M), 32'd0);
        check({tag, "_alu"}, ALUResult_W, 32'd0);
        check({tag, "_rdata"}, ReadData_W, 32'd0);
        check({tag, "_pc"}, PCPlus4_W, 32'd0);
        check({tag, "_ctl"}, {20'd0, RD_W, rd_wren_W, insn_vld_W, wb_sel_W, fault_W}, 32'd0);
    endtask

    initial begin
        bit st;
        logic [1:0] wbs;
        logic [2:0] f3;
        logic [31:0] a;
        int dly, kind;
        logic [2:0] legal_ld [5];
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        i_reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("rst");
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        run_op(1, 0, 2'b01, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1);
        check("tp_lw_data", ReadData_W, 32'hDEAD_BEEF);
        check("tp_lw_stalls", 32'(last_stalls), 32'd0);

        run_op(1, 0, 2'b01, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 3, 1);
        check("tp_lb_data", ReadData_W, 32'hFFFF_FF80);
        check("tp_lb_stalls", 32'(last_stalls), 32'd3);
        run_op(1, 0, 2'b01, 3'b100, 32'h103, 32'h0, 32'h8011_2233, 3, 1);
        check("tp_lbu_data", ReadData_W, 32'h0000_0080);

        run_op(1, 1, 2'b00, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 1, 0);
        check("tp_sh_be", 32'(first_be), 32'h0000_000C);
        check("tp_sh_wdata", first_wdata, 32'hABCD_ABCD);
        check("tp_sh_addr", first_addr, 32'h100);

        run_op(1, 0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h1234_5678, 0, 1);
        check("tp_mis_fault", 32'(fault_W), 32'd1);
        check("tp_mis_reqs", 32'(last_reqs), 32'd0);
        run_op(1, 0, 2'b01, 3'b011, 32'h100, 32'h0, 32'h1234_5678, 0, 1);
        check("tp_ill_fault", 32'(fault_W), 32'd3);

        run_op(1, 0, 2'b01, 3'b010, 32'h200, 32'h0, 32'h0, NEVER, 1);
        check("tp_tmo_reqs", 32'(last_reqs), 32'(MW));
        check("tp_tmo_stalls", 32'(last_stalls), 32'(MW - 1));
        check("tp_tmo_fault", 32'(fault_W), 32'd2);
        run_op(1, 0, 2'b00, 3'b000, 32'h55, 32'h0, 32'hCAFE_F00D, 0, 1);
        check("tp_late_ack", ReadData_W, 32'd0);

        // ack arriving on the final allowed cycle beats the abort
        run_op(1, 0, 2'b01, 3'b101, 32'h302, 32'h0, 32'hF00D_1234, MW - 1, 1);
        check("tp_last_ack", ReadData_W, 32'h0000_F00D);

        // reset asserted while an access is waiting
        ALUResult_M = 32'h400; funct3_M = 3'b010; wb_sel_M = 2'b01; insn_vld_M = 1;
        rd_wren_M = 1; mem_wren_M = 0; PCPlus4_M = 32'h44; RD_M = 5'd7; i_dmem_ack = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        idle_inputs();
        #1;
        check_all_zero("rst_wait");
        m_alu = '0; m_rdata = '0; m_pc = '0; m_rd = '0; m_wbsel = '0;
        @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        run_op(1, 0, 2'b01, 3'b010, 32'h500, 32'h0, 32'h0BAD_F00D, 1, 1);
        check("tp_post_rst", ReadData_W, 32'h0BAD_F00D);

        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & ~32'd3;
            dly = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 5);
            if (kind <= 3) begin
                st = 0; wbs = 2'b01;
                f3 = ($urandom_range(0, 6) == 0) ? 3'($urandom) : legal_ld[$urandom_range(0, 4)];
            end else if (kind <= 6) begin
                st = 1; wbs = 2'b00;
                f3 = ($urandom_range(0, 6) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            end else begin
                st = 0; wbs = $urandom_range(0, 1) ? 2'b10 : 2'b00;
                f3 = 3'($urandom);
            end
            run_op($urandom_range(0, 7) != 0, st, wbs, f3, a, $urandom, $urandom, dly,
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
